// File: rtl/gpu_raster_pkg.sv
// Shared raster constants and the edge walker state encoding.
package gpu_raster_pkg;
  localparam int XW_DEF   = 9;
  localparam int YW_DEF   = 8;
  localparam int FRAC_DEF = 8;
  localparam int HRES_DEF = 320;
  localparam int VRES_DEF = 200;

  localparam int ACC_W   = XW_DEF + FRAC_DEF + 1;
  localparam int DIV_CYC = XW_DEF + FRAC_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DIV,
    ST_WALK,
    ST_FIN
  } walk_state_t;
endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, N cycles per divide.
module seq_divider #(
  parameter int N = 17,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [D-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_quot
);
  localparam int CW = $clog2(N + 1);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_q;
  logic [D-1:0]  r_rem;
  logic [D-1:0]  r_dvs;

  logic [D:0]    w_sh;
  logic [D-1:0]  w_diff;
  logic          w_ge;
  logic [D-1:0]  w_rem_nxt;
  logic [N-1:0]  w_q_nxt;

  // r_q shifts the dividend out of its top while quotient bits enter at the bottom
  assign w_sh      = {r_rem, r_q[N-1]};
  assign w_ge      = (w_sh >= {1'b0, r_dvs});
  assign w_diff    = w_sh[D-1:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_diff : w_sh[D-1:0];
  assign w_q_nxt   = {r_q[N-2:0], w_ge};

  // Quotient is presented alongside done so the caller can latch it on the final edge
  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CW'(N - 1));
  assign o_quot = w_q_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_q    <= i_dividend;
      r_rem  <= '0;
      r_dvs  <= i_divisor;
    end else if (r_busy) begin
      r_q   <= w_q_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/edge_span_walker.sv
// Walks a polygon edge top to bottom, emitting one rounded x per visible scanline.
module edge_span_walker
  import gpu_raster_pkg::*;
#(
  parameter int XW   = XW_DEF,
  parameter int YW   = YW_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int HRES = HRES_DEF,
  parameter int VRES = VRES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] x1,
  input  logic [XW-1:0] x2,
  input  logic [YW-1:0] y1,
  input  logic [YW-1:0] y2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [YW-1:0] out_y,
  output logic [XW-1:0] out_x,
  output logic          out_last,
  output logic          done,
  output logic          busy
);
  localparam int AW = XW + FRAC + 1;
  localparam int DW = XW + FRAC;
  localparam logic [XW-1:0] XMAX = XW'(HRES - 1);
  localparam logic [YW-1:0] YMAX = YW'(VRES - 1);

  walk_state_t r_state, w_nxt;

  logic [XW-1:0] r_xt, r_xb;
  logic [YW-1:0] r_yt, r_yb, r_y, r_yend;
  logic          r_neg, r_skip;
  logic signed [AW-1:0] r_acc, r_slope;

  logic [XW-1:0] w_x1c, w_x2c;
  logic          w_swap;
  logic [YW-1:0] w_dy;
  logic [XW:0]   w_dx;
  logic [XW-1:0] w_adx;
  logic          w_div_start, w_div_busy, w_div_done;
  logic [DW-1:0] w_quot;
  logic signed [AW-1:0] w_acc0, w_slope_mag;
  logic          w_last;
  logic [XW:0]   w_rnd;

  assign w_x1c  = (x1 > XMAX) ? XMAX : x1;
  assign w_x2c  = (x2 > XMAX) ? XMAX : x2;
  assign w_swap = (y2 < y1) || ((y2 == y1) && (w_x2c < w_x1c));

  assign w_dy  = r_yb - r_yt;
  assign w_dx  = {1'b0, r_xb} - {1'b0, r_xt};
  assign w_adx = w_dx[XW] ? (~w_dx[XW-1:0] + 1'b1) : w_dx[XW-1:0];

  assign w_div_start = (r_state == ST_SETUP) && (w_dy != '0) && !w_div_busy;

  seq_divider #(.N(DW), .D(YW)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend ({w_adx, {FRAC{1'b0}}}),
    .i_divisor  (w_dy),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  assign w_acc0      = {1'b0, r_xt, {FRAC{1'b0}}};
  assign w_slope_mag = {1'b0, w_quot};
  assign w_last      = (r_y == r_yend);

  // Round half up: integer part plus the first fractional bit
  assign w_rnd = {1'b0, r_acc[XW+FRAC-1:FRAC]} + {{XW{1'b0}}, r_acc[FRAC-1]};

  always_comb begin
    if (r_acc[AW-1])             out_x = '0;
    else if (w_rnd > {1'b0, XMAX}) out_x = XMAX;
    else                         out_x = w_rnd[XW-1:0];
  end

  assign out_y = r_y;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_nxt = ST_SETUP;
      end
      ST_SETUP: w_nxt = (w_dy != '0) ? ST_DIV : ST_WALK;
      ST_DIV:   if (w_div_done) w_nxt = ST_WALK;
      ST_WALK: begin
        if (r_skip) w_nxt = ST_FIN;
        else begin
          out_valid = 1'b1;
          out_last  = w_last;
          if (out_ready && w_last) w_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        done  = 1'b1;
        w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_xt    <= '0;
      r_xb    <= '0;
      r_yt    <= '0;
      r_yb    <= '0;
      r_y     <= '0;
      r_yend  <= '0;
      r_neg   <= 1'b0;
      r_skip  <= 1'b0;
      r_acc   <= '0;
      r_slope <= '0;
    end else begin
      if ((r_state == ST_IDLE) && in_valid) begin
        if (w_swap) begin
          r_xt <= w_x2c; r_yt <= y2; r_xb <= w_x1c; r_yb <= y1;
        end else begin
          r_xt <= w_x1c; r_yt <= y1; r_xb <= w_x2c; r_yb <= y2;
        end
      end
      if (r_state == ST_SETUP) begin
        r_neg   <= w_dx[XW];
        r_y     <= r_yt;
        r_yend  <= (r_yb > YMAX) ? YMAX : r_yb;
        r_skip  <= (r_yt > YMAX);
        r_slope <= '0;
        // Horizontal edges skip the divider, so the accumulator is seeded here
        if (w_dy == '0) r_acc <= w_acc0;
      end
      if ((r_state == ST_DIV) && w_div_done) begin
        r_slope <= r_neg ? -w_slope_mag : w_slope_mag;
        r_acc   <= w_acc0;
      end
      if (out_valid && out_ready) begin
        r_acc <= r_acc + r_slope;
        if (!w_last) r_y <= r_y + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_edge_span_walker.sv
// Table-driven scoreboard bench for edge_span_walker, plus mid-edge reset sequences.
module tb_edge_span_walker;
  typedef struct {
    int x1, y1, x2, y2;
    int bp;
    int en, ey0, ex0, exl;
  } vec_t;
  typedef struct { int y, x, l; } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [8:0] x1 = '0, x2 = '0;
  logic [7:0] y1 = '0, y2 = '0;
  logic       in_ready, out_valid, out_last, done, busy;
  logic [7:0] out_y;
  logic [8:0] out_x;

  int    errors = 0;
  int    checks = 0;
  beat_t sb[$];
  vec_t  vt[9];

  always #5 clk = ~clk;

  edge_span_walker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .y1        (y1),
    .y2        (y2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_x     (out_x),
    .out_last  (out_last),
    .done      (done),
    .busy      (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input int c, input int d);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", in_ready, 1);
    x1 = 9'(a); y1 = 8'(b); x2 = 9'(c); y2 = 8'(d);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_edge(input vec_t v, input string nm);
    int xa, xb, xt, yt, xbt, ybt, dy, dx, slope, yend, lat, a;
    int c, first_c, last_c, done_c, nb, fy, fx, lx, stalled, py, px, pl;
    beat_t b;
    first_c = -1; last_c = -1; done_c = -1; nb = 0;
    fy = -1; fx = -1; lx = -1; stalled = 0; py = 0; px = 0; pl = 0;
    xa = (v.x1 > 319) ? 319 : v.x1;
    xb = (v.x2 > 319) ? 319 : v.x2;
    if (v.y2 < v.y1 || (v.y2 == v.y1 && xb < xa)) begin
      xt = xb; yt = v.y2; xbt = xa; ybt = v.y1;
    end else begin
      xt = xa; yt = v.y1; xbt = xb; ybt = v.y2;
    end
    dy = ybt - yt;
    dx = xbt - xt;
    if (dy == 0)     slope = 0;
    else if (dx < 0) slope = -(((-dx) * 256) / dy);
    else             slope = (dx * 256) / dy;
    sb.delete();
    if (yt <= 199) begin
      yend = (ybt > 199) ? 199 : ybt;
      for (int y = yt; y <= yend; y++) begin
        a   = xt * 256 + (y - yt) * slope;
        b.y = y;
        b.x = (a < 0) ? 0 : (a + 128) / 256;
        if (b.x > 319) b.x = 319;
        b.l = (y == yend) ? 1 : 0;
        sb.push_back(b);
      end
    end
    lat = (dy == 0) ? 2 : 19;

    drive(v.x1, v.y1, v.x2, v.y2);
    c = 1;
    chk({nm, "_busy_setup"}, busy, 1);
    while (c < 3000) begin
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        if (stalled != 0) begin
          chk({nm, "_hold_y"}, int'(out_y), py);
          chk({nm, "_hold_x"}, int'(out_x), px);
          chk({nm, "_hold_last"}, int'(out_last), pl);
        end
        out_ready = (v.bp != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (out_ready) begin
          if (sb.size() == 0) chk({nm, "_extra_beat"}, 1, 0);
          else begin
            b = sb.pop_front();
            chk({nm, "_y"}, int'(out_y), b.y);
            chk({nm, "_x"}, int'(out_x), b.x);
            chk({nm, "_last"}, int'(out_last), b.l);
          end
          if (nb == 0) begin fy = int'(out_y); fx = int'(out_x); end
          nb++;
          lx = int'(out_x);
          if (out_last) last_c = c;
          stalled = 0;
        end else begin
          stalled = 1; py = int'(out_y); px = int'(out_x); pl = int'(out_last);
        end
      end else begin
        if (stalled != 0) chk({nm, "_valid_drop"}, 0, 1);
        stalled = 0;
      end
      if (done) begin
        done_c = c;
        break;
      end
      @(negedge clk);
      c++;
    end
    out_ready = 1'b1;
    chk({nm, "_done_seen"}, (done_c > 0) ? 1 : 0, 1);
    chk({nm, "_nbeats"}, nb, v.en);
    chk({nm, "_sb_left"}, sb.size(), 0);
    if (v.en > 0) begin
      chk({nm, "_first_y"}, fy, v.ey0);
      chk({nm, "_first_x"}, fx, v.ex0);
      chk({nm, "_final_x"}, lx, v.exl);
      chk({nm, "_latency"}, first_c, lat);
      chk({nm, "_done_after_last"}, done_c, last_c + 1);
    end else begin
      chk({nm, "_done_cycle"}, done_c, lat + 1);
    end
    @(negedge clk);
    chk({nm, "_in_ready_after"}, in_ready, 1);
    chk({nm, "_done_one_cycle"}, done, 0);
  endtask

  task automatic reset_mid(input int wc, input string nm);
    int dcnt = 0;
    sb.delete();
    out_ready = 1'b1;
    drive(0, 0, 4, 8);
    repeat (wc) @(negedge clk);
    chk({nm, "_busy_before"}, busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_last"}, out_last, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_x"}, int'(out_x), 0);
    chk({nm, "_y"}, int'(out_y), 0);
    rst = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready, 1);
    repeat (24) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk({nm, "_no_done"}, dcnt, 0);
  endtask

  initial begin
    //        x1   y1   x2   y2  bp   en  ey0  ex0  exl
    vt[0] = '{10,   5,  10,   8,  0,   4,   5,  10,  10};
    vt[1] = '{0,    0,   4,   8,  0,   9,   0,   0,   4};
    vt[2] = '{100, 50,  90,  40,  0,  11,  40,  90, 100};
    vt[3] = '{30,   7,  12,   7,  0,   1,   7,  12,  12};
    vt[4] = '{5,  190,   5, 250,  0,  10, 190,   5,   5};
    vt[5] = '{50, 220,  60, 240,  0,   0,   0,   0,   0};
    vt[6] = '{400, 20, 300,  10,  0,  11,  10, 300, 319};
    vt[7] = '{200,  0, 100,   3,  0,   4,   0, 200, 100};
    vt[8] = '{0,    0, 319, 199,  1, 200,   0,   0, 319};

    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", int'(out_x), 0);
    chk("rst_y", int'(out_y), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_edge(vt[i], $sformatf("v%0d", i));

    reset_mid(5, "rst_div");
    run_edge(vt[1], "post_div");
    reset_mid(21, "rst_walk");
    run_edge(vt[0], "post_walk");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
